muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the sequential successor to the combinational ALU controller path for funcodes 0x18/0x19 (mult/multu), 0x1A/0x1B (div/divu) and 0x11/0x13 (mthi/mtlo). It sits beside the ALU in EX and raises a stall request to the hazard unit while an operation is in flight. mfhi/mflo read the hi/lo outputs directly.

Parameters:
WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  launch op in the current cycle (EX-stage valid)
op  in  3  MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; 6/7 are no-ops
a  in  WIDTH  rs operand
b  in  WIDTH  rt operand
flush  in  1  pipeline flush; aborts the in-flight op
busy  out  1  high while an op is in flight
stall_req  out  1  busy OR (start AND op is mult/div); combinational
done  out  1  one-cycle pulse when HI/LO are updated by mult/div
div_zero  out  1  sticky; set on a divide with b==0, cleared by the next start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter=0.
- FSM states: IDLE, PREP, ITER, FIX, DONE.
- IDLE, start=1:
  - mthi/mtlo: write a into hi/lo at the next edge; stay in IDLE; busy and done stay 0.
  - mult/div: capture operands, go to PREP.
  - op 6/7: ignored.
- PREP (1 cycle): for signed ops, take |a| and |b|; record the result signs (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa). Load counter=WIDTH, then go to ITER.
- ITER (WIDTH cycles): radix-2 steps.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Remainder is held in WIDTH+1 bits.
  - Counter decrements each cycle; at 0, go to FIX.
- FIX (1 cycle): apply sign correction (two's complement). Write hi = product[2W-1:W] or remainder, and lo = product[W-1:0] or quotient. Go to DONE.
- DONE (1 cycle): done=1, busy=0; return to IDLE. A start in DONE is accepted as if in IDLE.
- Latency: start at edge N → done=1 during cycle N+WIDTH+3. busy is high from cycle N+1 through N+WIDTH+2.
- start while busy: ignored. Hazard unit holds EX via stall_req.
- Divide by zero: skip ITER. In FIX write hi=a (original), lo={WIDTH{1'b1}}; div_zero=1; done pulses normally. Latency is 3 cycles.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0; no flag.
- flush while busy: go to IDLE next edge; hi/lo unchanged; no done pulse. flush in IDLE with start=1 suppresses the start, including mthi/mtlo.
- flush and start in the same cycle: flush wins.
- rst mid-operation: immediate return to reset values.
- All arithmetic is unsigned internally; no X propagation from unused accumulator bits.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: in a multiply, ITER exits to FIX as soon as the remaining multiplier bits are all zero; the accumulator is aligned by the remaining count in FIX. Multiply latency becomes 3 + (index of the highest set bit of |b|) + 1. A zero multiplier gives done at N+3. Divide latency is unchanged.
- Undefined: fixed WIDTH-cycle ITER for all ops.
- hi/lo results are identical in both builds.

Decomposition:
- Package muldiv_pkg: op encodings MD_*, FSM state enum, and the md_op_t typedef (3 bits).
- One sub-module, muldiv_datapath: accumulator/remainder registers plus one add/sub step, driven by FSM controls. The FSM, HI/LO and flags stay in muldiv_unit.

Test Plan:
- WIDTH=32, mult a=-3 (0xFFFFFFFD), b=7 → done at start+35; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 34 cycles.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. div a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu a=100, b=0 → done at start+3, div_zero=1, hi=100, lo=0xFFFFFFFF. The next mthi start clears div_zero and sets hi=a after 1 cycle with no done pulse.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Assert flush at cycle 10 of a subsequent mult → no done pulse; hi/lo hold the prior values; busy=0 next cycle.
- Assert rst asynchronously mid-ITER → all outputs 0 before the next clk edge. A start during busy is ignored and stall_req stays 1.
- With MULDIV_EARLY_TERM_EN: multu a=5, b=3 → done at start+5, lo=15, hi=0. Without the macro: same result at start+35.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and small op-class helpers.
package muldiv_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MTHI  = 3'd4;
  localparam md_op_t MD_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } md_state_t;

  // mult/multu/div/divu all live in the lower half of the op space
  function automatic logic is_arith(input md_op_t op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_valid_op(input md_op_t op);
    return (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 step engine: 2*WIDTH accumulator, multiplier/quotient shift register
// and one shared add/sub used for shift-add multiply or restoring divide.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     mq_init,
  input  logic [WIDTH-1:0]     opnd_init,
  output logic [2*WIDTH-1:0]   acc,
  output logic [WIDTH-1:0]     mq
);

  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mq_reg;
  logic [WIDTH-1:0]   opnd_reg;

  logic [WIDTH+1:0]   x;
  logic [WIDTH+1:0]   y;
  logic [WIDTH+1:0]   res;
  logic               borrow;
  logic [WIDTH-1:0]   rem_next;

  // Divide: the partial remainder shifted left with the next dividend bit is the
  // WIDTH+1 bit trial value; the extra top bit of res carries the borrow.
  always_comb begin
    if (is_div) begin
      x = {1'b0, acc_reg[2*WIDTH-1:WIDTH], mq_reg[WIDTH-1]};
      y = {2'b00, opnd_reg};
    end else begin
      x = {2'b00, acc_reg[2*WIDTH-1:WIDTH]};
      y = mq_reg[0] ? {2'b00, opnd_reg} : '0;
    end
    res      = is_div ? (x - y) : (x + y);
    borrow   = res[WIDTH+1];
    rem_next = borrow ? x[WIDTH-1:0] : res[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      mq_reg   <= '0;
      opnd_reg <= '0;
    end else if (load) begin
      acc_reg  <= '0;
      mq_reg   <= mq_init;
      opnd_reg <= opnd_init;
    end else if (step) begin
      if (is_div) begin
        acc_reg <= {rem_next, acc_reg[WIDTH-1:0]};
        mq_reg  <= {mq_reg[WIDTH-2:0], ~borrow};
      end else begin
        acc_reg <= {res[WIDTH:0], acc_reg[WIDTH-1:1]};
        mq_reg  <= {1'b0, mq_reg[WIDTH-1:1]};
      end
    end
  end

  assign acc = acc_reg;
  assign mq  = mq_reg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers and a stall request for EX.
// Build option: MULDIV_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state_reg, state_next;
  md_op_t           op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, hi_reg, lo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_lo_reg, neg_hi_reg, div_zero_reg;

  logic             accept, dp_load, dp_step, fix_write;
  logic             op_div, op_signed, a_neg, b_neg, b_zero;
  logic             mul_skip, mul_last;
  logic [WIDTH-1:0] mag_a, mag_b, mq, rem_raw, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] acc, prod_raw, prod;

  assign op_div    = is_div_op(op_reg);
  assign op_signed = is_signed_op(op_reg);
  assign a_neg     = op_signed & a_reg[WIDTH-1];
  assign b_neg     = op_signed & b_reg[WIDTH-1];
  assign mag_a     = a_neg ? -a_reg : a_reg;
  assign mag_b     = b_neg ? -b_reg : b_reg;
  assign b_zero    = (b_reg == '0);

`ifdef MULDIV_EARLY_TERM_EN
  // After k steps the accumulator holds the product scaled by 2^(WIDTH-k).
  assign mul_skip = ~op_div & (mag_b == '0);
  assign mul_last = ~op_div & (mq[WIDTH-1:1] == '0);
  assign prod_raw = acc >> cnt_reg;
`else
  assign mul_skip = 1'b0;
  assign mul_last = 1'b0;
  assign prod_raw = acc;
`endif

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (op_div),
    .mq_init   (op_div ? mag_a : mag_b),
    .opnd_init (op_div ? mag_b : mag_a),
    .acc       (acc),
    .mq        (mq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        done       = (state_reg == ST_DONE);
        state_next = ST_IDLE;
        if (start && !flush && is_valid_op(op)) begin
          accept = 1'b1;
          if (is_arith(op)) state_next = ST_PREP;
        end
      end
      ST_PREP: begin
        busy    = 1'b1;
        dp_load = 1'b1;
        if (flush)                          state_next = ST_IDLE;
        else if ((op_div && b_zero) || mul_skip) state_next = ST_FIX;
        else                                state_next = ST_ITER;
      end
      ST_ITER: begin
        busy    = 1'b1;
        dp_step = 1'b1;
        if (flush)                                      state_next = ST_IDLE;
        else if ((cnt_reg == CNT_W'(1)) || mul_last)    state_next = ST_FIX;
      end
      ST_FIX: begin
        busy       = 1'b1;
        state_next = flush ? ST_IDLE : ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fix_write = (state_reg == ST_FIX) && !flush;
  assign stall_req = busy | (start & is_arith(op));

  always_comb begin
    prod    = neg_lo_reg ? -prod_raw : prod_raw;
    rem_raw = acc[2*WIDTH-1:WIDTH];
    if (op_div) begin
      if (b_zero) begin
        hi_fix = a_reg;
        lo_fix = '1;
      end else begin
        hi_fix = neg_hi_reg ? -rem_raw : rem_raw;
        lo_fix = neg_lo_reg ? -mq : mq;
      end
    end else begin
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg       <= MD_MULT;
      a_reg        <= '0;
      b_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      cnt_reg      <= '0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      if (accept) begin
        div_zero_reg <= 1'b0;
        op_reg       <= op;
        a_reg        <= a;
        b_reg        <= b;
        if (op == MD_MTHI) hi_reg <= a;
        if (op == MD_MTLO) lo_reg <= a;
      end
      if (state_reg == ST_PREP) begin
        cnt_reg    <= CNT_W'(WIDTH);
        neg_lo_reg <= a_neg ^ b_neg;
        neg_hi_reg <= a_neg;
      end
      if (dp_step) cnt_reg <= cnt_reg - 1'b1;
      if (fix_write) begin
        hi_reg <= hi_fix;
        lo_reg <= lo_fix;
        if (op_div && b_zero) div_zero_reg <= 1'b1;
      end
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, stall_req, done, div_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input logic [W-1:0] m);
    int l;
    l = W + 3;
`ifdef MULDIV_EARLY_TERM_EN
    l = 3;
    for (int i = 0; i < W; i++) if (m[i]) l = 4 + i;
`endif
    return l;
  endfunction

  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl,
                                 output int lat, output logic dz);
    longint       sx, sy, p, q, r;
    logic [63:0]  up;
    logic [W-1:0] m;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    rh  = m_hi;
    rl  = m_lo;
    lat = W + 3;
    dz  = 1'b0;
    case (o)
      3'd0: begin
        p = sx * sy;
        rh = p[2*W-1:W]; rl = p[W-1:0];
        m = y[W-1] ? -y : y;
        lat = mul_lat(m);
      end
      3'd1: begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[2*W-1:W]; rl = up[W-1:0];
        lat = mul_lat(y);
      end
      default: begin
        if (y == '0) begin
          rh = x; rl = '1; dz = 1'b1; lat = 3;
        end else if (o == 3'd2) begin
          q = sx / sy; r = sx % sy;
          rh = r[W-1:0]; rl = q[W-1:0];
        end else begin
          rh = x % y; rl = x / y;
        end
      end
    endcase
  endfunction

  task automatic wait_done(input int k_start, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = k_start; k < k_start + 100; k++) begin
      if (busy) bc++;
      if (done) begin
        lat = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_arith(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el;
    logic         edz;
    int           elat, lat, bc;
    ref_op(o, x, y, eh, el, elat, edz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 check("stall_req_on_start", 64'(stall_req), 64'(1));
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    wait_done(0, lat, bc);
    check("latency", 64'(lat), 64'(elat));
    check("busy_cycles", 64'(bc), 64'(elat - 1));
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("div_zero", 64'(div_zero), 64'(edz));
    m_hi = eh; m_lo = el; m_dz = edz;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d dz=%0b", o, x, y, hi, lo, lat, div_zero);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x, input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; a = x; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    if (!fl) begin
      if (o == 3'd4) m_hi = x;
      else           m_lo = x;
      m_dz = 1'b0;
    end
    check("mt_busy", 64'(busy), 64'(0));
    check("mt_done", 64'(done), 64'(0));
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
    check("mt_div_zero", 64'(div_zero), 64'(m_dz));
    $display("op=%0d a=%h flush=%0b -> hi=%h lo=%h", o, x, fl, hi, lo);
  endtask

  task automatic run_noop(input logic [2:0] o);
    @(negedge clk);
    start = 1'b1; op = o; a = $urandom; b = $urandom;
    #1 check("noop_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    check("noop_busy", 64'(busy), 64'(0));
    check("noop_hi", 64'(hi), 64'(m_hi));
    check("noop_lo", 64'(lo), 64'(m_lo));
    $display("op=%0d ignored -> hi=%h lo=%h", o, hi, lo);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edge_vals [5];
    edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return W'($urandom_range(0, 20));
      2:       return edge_vals[$urandom_range(0, 4)];
      default: return -W'($urandom_range(1, 1000));
    endcase
  endfunction

  initial begin
    logic [W-1:0] eh, el, x, y;
    logic         edz;
    int           elat, lat, bc, dones;
    logic [2:0]   o;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    check("rst_stall", 64'(stall_req), 64'(0));
    @(negedge clk) rst = 1'b0;

    run_arith(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_arith(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_arith(3'd3, 32'd100, 32'd0);
    run_mt(3'd4, 32'hCAFE_0001, 1'b0);
    run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // flush in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd123; b = 32'h8000_0456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("flush_no_done", 64'(dones), 64'(0));
    check("flush_hi", 64'(hi), 64'(m_hi));
    check("flush_lo", 64'(lo), 64'(m_lo));
    $display("flushed mult -> hi=%h lo=%h", hi, lo);

    // flush beats a same-cycle mthi
    run_mt(3'd4, 32'h0000_55AA, 1'b1);

    // start while busy is ignored
    x = $urandom; y = $urandom | 32'h8000_0000;
    ref_op(3'd1, x, y, eh, el, elat, edz);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd0;
    #1 check("busy_start_stall", 64'(stall_req), 64'(1));
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, lat, bc);
    check("busy_start_lat", 64'(lat), 64'(elat));
    check("busy_start_hi", 64'(hi), 64'(eh));
    check("busy_start_lo", 64'(lo), 64'(el));
    check("busy_start_dz", 64'(div_zero), 64'(0));
    m_hi = eh; m_lo = el; m_dz = 1'b0;
    $display("multu a=%h b=%h with ignored start -> hi=%h lo=%h lat=%0d", x, y, hi, lo, lat);

    // asynchronous reset mid-iteration
    run_arith(3'd3, 32'd77, 32'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h1234_5678; b = 32'h8765_4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_div_zero", 64'(div_zero), 64'(0));
    @(negedge clk) rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    $display("async reset mid-op -> hi=%h lo=%h busy=%0b", hi, lo, busy);

    run_arith(3'd1, 32'd5, 32'd3);
    run_arith(3'd0, 32'd17, 32'd0);

    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if (o <= 3'd3)      run_arith(o, x, y);
      else if (o <= 3'd5) run_mt(o, x, ($urandom_range(0, 7) == 0));
      else                run_noop(o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
